// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 package link: receiver FSM states, framing
// constants and the default bit timing used by both transmitter and receiver.
package rs232_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;

  localparam int BITS_PER_BYTE  = 8;
  localparam int BYTES_PER_PKT  = 4;
  localparam int BIT_PERIOD_DEF = 50;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/rx_byte.sv
// 8N1 byte receiver: input synchronizer, start/data/stop/break FSM, and
// single-cycle byte_done / byte_bad strobes at the stop-bit sample.
module rx_byte
  import rs232_pkg::*;
#(
  parameter int BIT_PERIOD   = BIT_PERIOD_DEF,
  parameter int SAMPLE_POINT = 25,
  parameter int CNT_W        = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_in,
  output logic [BITS_PER_BYTE-1:0] byte_data,
  output logic                     byte_done,
  output logic                     byte_bad,
  output logic                     idle
);

  localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_POINT - 1);
  localparam logic [2:0]       IDX_LAST    = 3'(BITS_PER_BYTE - 1);

  logic             s_meta, s, s_prev;
  rx_state_e        state, state_n;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic             sample;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_meta <= 1'b1;
      s      <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s_meta <= data_in;
      s      <= s_meta;
      s_prev <= s;
    end
  end

  always_comb begin
    state_n   = state;
    sample    = 1'b0;
    byte_done = 1'b0;
    byte_bad  = 1'b0;
    case (state)
      IDLE:  if (s_prev && !s) state_n = START;
      // A line that is high again at mid start bit was only a glitch
      START: if (bit_cnt == SAMPLE_LAST) state_n = s ? IDLE : DATA;
      DATA: if (bit_cnt == BIT_LAST) begin
        sample = 1'b1;
        if (bit_idx == IDX_LAST) state_n = STOP;
      end
      STOP: if (bit_cnt == BIT_LAST) begin
        if (s) begin
          byte_done = 1'b1;
          state_n   = IDLE;
        end else begin
          byte_bad = 1'b1;
          state_n  = BREAK;
        end
      end
      BREAK:   if (s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      byte_data <= '0;
    end else begin
      state <= state_n;
      // Counter restarts on every state change and after every data sample
      if (state_n != state || sample || state_n == IDLE || state_n == BREAK)
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + 1'b1;
      if (state != DATA)
        bit_idx <= '0;
      else if (sample)
        bit_idx <= bit_idx + 1'b1;
      if (sample)
        byte_data <= {s, byte_data[BITS_PER_BYTE-1:1]};
    end
  end

  assign idle = (state == IDLE);

endmodule

// File: rtl/rx_package.sv
// Package receiver: assembles four received bytes into a 32-bit word, drops
// partial packages on framing errors or inter-byte gap timeout.
module rx_package
  import rs232_pkg::*;
#(
  parameter int BIT_PERIOD   = BIT_PERIOD_DEF,
  parameter int SAMPLE_POINT = 25,
  parameter int GAP_TIMEOUT  = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_in,
  output logic [31:0] data_out,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        pkt_err
);

  localparam int               CNT_W    = cnt_width(BIT_PERIOD, GAP_TIMEOUT);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TIMEOUT - 1);
  localparam logic [1:0]       CNT_LAST = 2'(BYTES_PER_PKT - 1);

  logic [BITS_PER_BYTE-1:0] byte_data;
  logic                     byte_done, byte_bad, idle;
  logic [1:0]               byte_cnt;
  logic [31:0]              word_q, word_n;
  logic [CNT_W-1:0]         gap_cnt;
  logic                     gap_run, gap_hit;

  rx_byte #(
    .BIT_PERIOD  (BIT_PERIOD),
    .SAMPLE_POINT(SAMPLE_POINT),
    .CNT_W       (CNT_W)
  ) u_rx_byte (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .byte_data(byte_data),
    .byte_done(byte_done),
    .byte_bad (byte_bad),
    .idle     (idle)
  );

  always_comb begin
    word_n = word_q;
    word_n[{byte_cnt, 3'b000} +: BITS_PER_BYTE] = byte_data;
  end

  // Gap timer only runs between bytes of a package that has been started
  assign gap_run = idle && (byte_cnt != 2'd0);
  assign gap_hit = gap_run && (gap_cnt == GAP_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      pkt_err   <= 1'b0;
      byte_cnt  <= '0;
      word_q    <= '0;
      gap_cnt   <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      pkt_err   <= 1'b0;
      gap_cnt   <= (gap_run && !gap_hit) ? gap_cnt + 1'b1 : '0;
      if (byte_done) begin
        if (byte_cnt == CNT_LAST) begin
          data_out <= word_n;
          rx_valid <= 1'b1;
          byte_cnt <= '0;
          word_q   <= '0;
        end else begin
          word_q   <= word_n;
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else if (byte_bad) begin
        frame_err <= 1'b1;
        byte_cnt  <= '0;
        word_q    <= '0;
      end else if (gap_hit) begin
        pkt_err  <= 1'b1;
        byte_cnt <= '0;
        word_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rx_package.sv
// Scoreboard bench for rx_package: a serial transmitter model pushes expected
// events, a negedge monitor pops and compares every output pulse.
module tb_rx_package;

  localparam int BP  = 50;
  localparam int GAP = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_in = 1'b1;
  logic [31:0] data_out;
  logic        rx_valid, frame_err, pkt_err;

  typedef struct {
    int          kind;  // 0 = package, 1 = frame error, 2 = gap timeout
    logic [31:0] word;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  rx_package #(.BIT_PERIOD(BP), .SAMPLE_POINT(25), .GAP_TIMEOUT(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .pkt_err  (pkt_err)
  );

  always #5 clk = ~clk;

  task automatic check_ev(input int kind, input string name);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected pulse, data_out=%h, none pending", name, data_out);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == 0 && data_out !== e.word)) begin
        bad++;
        $display("FAIL %s: got kind=%0d data_out=%h, required kind=%0d data=%h",
                 name, kind, data_out, e.kind, e.word);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid && frame_err) begin
        total++;
        bad++;
        $display("FAIL excl: rx_valid and frame_err both high");
      end
      if (rx_valid)  check_ev(0, "rx_valid");
      if (frame_err) check_ev(1, "frame_err");
      if (pkt_err)   check_ev(2, "pkt_err");
    end
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tx_bit(input logic b, input int n);
    data_in = b;
    repeat (n) @(negedge clk);
  endtask

  // jit cycles bit periods 49/50/51
  task automatic tx_byte(input logic [7:0] b, input logic stop, input bit jit);
    int k;
    int per;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      per = jit ? 49 + (k % 3) : BP;
      k++;
      if (i == 0)      tx_bit(1'b0, per);
      else if (i == 9) tx_bit(stop, per);
      else             tx_bit(b[i-1], per);
    end
    data_in = 1'b1;
  endtask

  task automatic tx_pkt(input logic [31:0] w, input bit jit);
    ev_t e;
    e.kind = 0;
    e.word = w;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) tx_byte(w[8*i +: 8], 1'b1, jit);
  endtask

  task automatic push_err(input int kind);
    ev_t e;
    e.kind = kind;
    e.word = '0;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain %s: pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    data_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    repeat (4) @(negedge clk);
    check_val("reset data_out", data_out, 32'h0);
    check_val("reset rx_valid", {31'b0, rx_valid}, 32'h0);
    check_val("reset frame_err", {31'b0, frame_err}, 32'h0);
    check_val("reset pkt_err", {31'b0, pkt_err}, 32'h0);
    rst = 1'b1;
    idle(20);

    // back-to-back packages
    tx_pkt(32'hDEADBEEF, 1'b0);
    tx_pkt(32'h00000001, 1'b0);
    idle(60);
    drain("back2back");

    // bit-period jitter
    tx_pkt(32'hA5A55A5A, 1'b1);
    idle(60);
    drain("jitter");

    // short glitch must not produce anything
    tx_bit(1'b0, 10);
    idle(100);
    drain("glitch");
    tx_pkt(32'h12345678, 1'b0);
    idle(60);
    drain("after glitch");

    // framing error on byte 2, package abandoned
    push_err(1);
    w = 32'h44332211;
    tx_byte(w[7:0], 1'b1, 1'b0);
    tx_byte(w[15:8], 1'b1, 1'b0);
    tx_byte(w[23:16], 1'b0, 1'b0);
    idle(100);
    drain("frame err");
    tx_pkt(32'h89ABCDEF, 1'b0);
    idle(60);
    drain("after frame err");

    // inter-byte gap timeout
    push_err(2);
    w = 32'h77665544;
    tx_byte(w[7:0], 1'b1, 1'b0);
    tx_byte(w[15:8], 1'b1, 1'b0);
    idle(GAP + 10);
    drain("gap");
    tx_pkt(32'hCAFEF00D, 1'b0);
    idle(60);
    drain("after gap");

    // reset during DATA of byte 1
    tx_byte(8'h3C, 1'b1, 1'b0);
    tx_bit(1'b0, BP);
    tx_bit(1'b1, BP);
    tx_bit(1'b0, 30);
    #2 rst = 1'b0;
    #1;
    check_val("async data_out", data_out, 32'h0);
    check_val("async rx_valid", {31'b0, rx_valid}, 32'h0);
    check_val("async frame_err", {31'b0, frame_err}, 32'h0);
    check_val("async pkt_err", {31'b0, pkt_err}, 32'h0);
    data_in = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    idle(20);
    tx_pkt(32'h0F0F0F0F, 1'b0);
    idle(60);
    drain("after reset");
    check_val("hold data_out", data_out, 32'h0F0F0F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
